// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame geometry and line levels.
// Used by both ends of the uart_master -> uart_slave link.
package uart_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    localparam int unsigned FRAME_BITS = 11;
    localparam logic        STOP_LVL   = 1'b0;
    localparam int unsigned BIT_CNT_W  = 3;

    // Even parity over the data byte, as the transmitter generates it.
    function automatic logic calc_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_rx_hold_reg.sv
// Valid/ready holding register for received frames.
// A completed frame loads only if the register is empty or drained this same edge; otherwise it is dropped with an overrun pulse.
module uart_rx_hold_reg #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_rx,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_perr,
    input  logic              load_ferr,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              u_rx_done
);

    logic can_load;

    assign can_load = !rx_valid || rx_ready;

    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            u_rx_done  <= 1'b0;
        end else begin
            overrun   <= 1'b0;
            u_rx_done <= load_valid;
            if (load_valid) begin
                if (can_load) begin
                    rx_data    <= load_data;
                    parity_err <= load_perr;
                    frame_err  <= load_ferr;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun    <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_slave.sv
// UART receiver: bit-rate sampled deserialiser for start, 8 data LSB first, even parity, stop(0).
// Completed frames are handed to a valid/ready holding register with error flags.
module uart_slave
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk_rx,
    input  logic              rst_n,
    input  logic              u_rx,
    input  logic              en_rx,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              u_rx_done,
    output logic              rx_busy
);

    rx_state_t            state_q, state_d;
    logic [BIT_CNT_W-1:0] cnt_q;
    logic [DATA_W-1:0]    shift_q;
    logic                 p_rx_q;
    logic                 line_bit;
    logic                 start_det;
    logic                 frame_done;
    logic                 stop_bad;
    logic                 perr_calc;

    // A floating or unknown line must never look like a start bit or a data 1.
    assign line_bit  = (u_rx === 1'b1);
    assign start_det = (u_rx === 1'b0) && en_rx;

    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        case (state_q)
            RX_IDLE:   if (start_det) state_d = RX_DATA;
            RX_DATA:   if (cnt_q == BIT_CNT_W'(DATA_W - 1)) state_d = RX_PARITY;
            RX_PARITY: state_d = RX_STOP;
            RX_STOP: begin
                state_d    = RX_IDLE;
                frame_done = 1'b1;
            end
            default:   state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_rx or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            shift_q <= '0;
            p_rx_q  <= 1'b0;
        end else begin
            case (state_q)
                RX_IDLE: if (start_det) cnt_q <= '0;
                RX_DATA: begin
                    shift_q[cnt_q] <= line_bit;
                    cnt_q          <= cnt_q + 1'b1;
                end
                RX_PARITY: p_rx_q <= line_bit;
                default: ;
            endcase
        end
    end

    // Stop sample is taken combinationally on the completion edge itself.
    assign stop_bad  = (line_bit != STOP_LVL);
    assign perr_calc = (p_rx_q != calc_parity(shift_q));
    assign rx_busy   = (state_q != RX_IDLE);

    uart_rx_hold_reg #(
        .DATA_W (DATA_W)
    ) u_hold (
        .clk_rx     (clk_rx),
        .rst_n      (rst_n),
        .load_valid (frame_done),
        .load_data  (shift_q),
        .load_perr  (perr_calc),
        .load_ferr  (stop_bad),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .u_rx_done  (u_rx_done)
    );

endmodule

// File: tb/tb_uart_slave.sv
// Directed self-checking bench for uart_slave; the bench itself plays the transmitter, driving u_rx on falling edges.
module tb_uart_slave;
    import uart_pkg::*;

    logic       clk_rx = 1'b0;
    logic       rst_n;
    logic       u_rx;
    logic       en_rx;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       u_rx_done;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;

    uart_slave #(.DATA_W(8)) dut (
        .clk_rx     (clk_rx),
        .rst_n      (rst_n),
        .u_rx       (u_rx),
        .en_rx      (en_rx),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .u_rx_done  (u_rx_done),
        .rx_busy    (rx_busy)
    );

    always #5 clk_rx = ~clk_rx;
    always @(posedge clk_rx) cyc++;
    always @(negedge clk_rx) if (u_rx_done === 1'b1) done_cnt++;

    // Called at a falling edge; returns at the falling edge just after the completion edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        u_rx = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_rx);
            u_rx = d[i];
        end
        @(negedge clk_rx);
        u_rx = p;
        @(negedge clk_rx);
        u_rx = s;
        @(negedge clk_rx);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; u_rx = 1'b1; en_rx = 1'b0; rx_ready = 1'b0;
        #3;
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, overrun, u_rx_done, rx_busy} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {rx_data, rx_valid, parity_err, frame_err, overrun, u_rx_done, rx_busy});
        end
        repeat (2) @(negedge clk_rx);
        rst_n = 1'b1; en_rx = 1'b1;
        @(negedge clk_rx);
    endtask

    task automatic test_loopback;
        int t0;
        rx_ready = 1'b0;
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b0);
        u_rx = 1'b1;
        checks++;
        if (cyc - t0 !== FRAME_BITS) begin errors++; $display("FAIL loop_latency got=%0d exp=%0d", cyc - t0, FRAME_BITS); end
        checks++;
        if ({u_rx_done, rx_valid, rx_data} !== {1'b1, 1'b1, 8'hA5}) begin
            errors++; $display("FAIL loop_data got=%b/%b/%h exp=1/1/a5", u_rx_done, rx_valid, rx_data);
        end
        checks++;
        if ({parity_err, frame_err, overrun} !== 3'b000) begin errors++; $display("FAIL loop_flags got=%b exp=000", {parity_err, frame_err, overrun}); end
        @(negedge clk_rx);
        checks++;
        if ({u_rx_done, rx_valid, rx_data} !== {1'b0, 1'b1, 8'hA5}) begin
            errors++; $display("FAIL loop_hold got=%b/%b/%h exp=0/1/a5", u_rx_done, rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        @(negedge clk_rx);
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL loop_drain got=%b exp=0", rx_valid); end
    endtask

    task automatic test_back_to_back;
        int t1, n0;
        rx_ready = 1'b1;
        n0 = done_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        t1 = cyc;
        checks++;
        if ({rx_valid, rx_data, parity_err, frame_err} !== {1'b1, 8'h3C, 2'b00}) begin
            errors++; $display("FAIL b2b_first got=%b/%h/%b%b exp=1/3c/00", rx_valid, rx_data, parity_err, frame_err);
        end
        send_frame(8'hFF, 1'b0, 1'b0);
        u_rx = 1'b1;
        checks++;
        if ({u_rx_done, rx_valid, rx_data, parity_err, frame_err} !== {2'b11, 8'hFF, 2'b00}) begin
            errors++; $display("FAIL b2b_second got=%b/%b/%h/%b%b exp=1/1/ff/00", u_rx_done, rx_valid, rx_data, parity_err, frame_err);
        end
        checks++;
        if (cyc - t1 !== 11) begin errors++; $display("FAIL b2b_period got=%0d exp=11", cyc - t1); end
        @(negedge clk_rx);
        rx_ready = 1'b0;
        checks++;
        if (done_cnt - n0 !== 2) begin errors++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt - n0); end
    endtask

    task automatic test_parity_inject;
        rx_ready = 1'b0;
        send_frame(8'h01, 1'b0, 1'b0);
        u_rx = 1'b1;
        checks++;
        if ({rx_valid, rx_data, parity_err, frame_err} !== {1'b1, 8'h01, 2'b10}) begin
            errors++; $display("FAIL parity_err got=%b/%h/%b%b exp=1/01/10", rx_valid, rx_data, parity_err, frame_err);
        end
        rx_ready = 1'b1;
        @(negedge clk_rx);
        rx_ready = 1'b0;
        checks++;
        if ({rx_valid, parity_err, frame_err} !== 3'b000) begin
            errors++; $display("FAIL flag_clear got=%b exp=000", {rx_valid, parity_err, frame_err});
        end
        send_frame(8'h01, 1'b1, 1'b1);
        u_rx = 1'b1;
        checks++;
        if ({rx_valid, rx_data, parity_err, frame_err} !== {1'b1, 8'h01, 2'b01}) begin
            errors++; $display("FAIL frame_err got=%b/%h/%b%b exp=1/01/01", rx_valid, rx_data, parity_err, frame_err);
        end
        rx_ready = 1'b1;
        @(negedge clk_rx);
        rx_ready = 1'b0;
    endtask

    task automatic test_overrun;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0);
        checks++;
        if ({rx_valid, rx_data, overrun} !== {1'b1, 8'h11, 1'b0}) begin
            errors++; $display("FAIL ovr_first got=%b/%h/%b exp=1/11/0", rx_valid, rx_data, overrun);
        end
        send_frame(8'h22, 1'b0, 1'b0);
        u_rx = 1'b1;
        checks++;
        if ({u_rx_done, overrun, rx_valid, rx_data} !== {3'b111, 8'h11}) begin
            errors++; $display("FAIL ovr_pulse got=%b/%b/%b/%h exp=1/1/1/11", u_rx_done, overrun, rx_valid, rx_data);
        end
        @(negedge clk_rx);
        checks++;
        if ({overrun, rx_valid, rx_data} !== {2'b01, 8'h11}) begin
            errors++; $display("FAIL ovr_single got=%b/%b/%h exp=0/1/11", overrun, rx_valid, rx_data);
        end
        rx_ready = 1'b1;
        @(negedge clk_rx);
        rx_ready = 1'b0;
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drain got=%b exp=0", rx_valid); end
    endtask

    task automatic test_idle_line;
        logic probe;
        logic busy_seen;
        int   n0;
        busy_seen = 1'b0;
        n0 = done_cnt;
        en_rx = 1'b1;
        u_rx = 1'b1;
        repeat (20) begin @(negedge clk_rx); busy_seen |= rx_busy; end
        // Floating/unknown levels are only meaningful on a four-state simulator.
        probe = 1'bz;
        if (probe === 1'bz) begin
            u_rx = 1'bz;
            repeat (15) begin @(negedge clk_rx); busy_seen |= rx_busy; end
            u_rx = 1'bx;
            repeat (15) begin @(negedge clk_rx); busy_seen |= rx_busy; end
        end else begin
            repeat (30) begin @(negedge clk_rx); busy_seen |= rx_busy; end
        end
        checks++;
        if (busy_seen !== 1'b0) begin errors++; $display("FAIL idle_busy got=%b exp=0", busy_seen); end
        en_rx = 1'b0;
        u_rx = 1'b0;
        repeat (20) begin @(negedge clk_rx); busy_seen |= rx_busy; end
        u_rx = 1'b1;
        en_rx = 1'b1;
        @(negedge clk_rx);
        checks++;
        if (busy_seen !== 1'b0) begin errors++; $display("FAIL en_gate_busy got=%b exp=0", busy_seen); end
        checks++;
        if (done_cnt - n0 !== 0) begin errors++; $display("FAIL idle_done got=%0d exp=0", done_cnt - n0); end
    endtask

    task automatic test_reset_midframe;
        int n0;
        rx_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b0);
        n0 = done_cnt;
        u_rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_rx);
            u_rx = 1'b1;
        end
        @(negedge clk_rx);
        checks++;
        if ({rx_busy, rx_valid} !== 2'b11) begin errors++; $display("FAIL mid_pre got=%b exp=11", {rx_busy, rx_valid}); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rx_data, rx_valid, parity_err, frame_err, overrun, u_rx_done, rx_busy} !== 14'h0) begin
            errors++; $display("FAIL mid_reset got=%h exp=0", {rx_data, rx_valid, parity_err, frame_err, overrun, u_rx_done, rx_busy});
        end
        @(negedge clk_rx);
        rst_n = 1'b1;
        @(negedge clk_rx);
        send_frame(8'h5A, 1'b0, 1'b0);
        u_rx = 1'b1;
        checks++;
        if ({rx_valid, rx_data, parity_err, frame_err} !== {1'b1, 8'h5A, 2'b00}) begin
            errors++; $display("FAIL after_reset got=%b/%h/%b%b exp=1/5a/00", rx_valid, rx_data, parity_err, frame_err);
        end
        checks++;
        if (done_cnt - n0 !== 1) begin errors++; $display("FAIL mid_done_count got=%0d exp=1", done_cnt - n0); end
    endtask

    initial begin
        test_reset;
        test_loopback;
        test_back_to_back;
        test_parity_inject;
        test_overrun;
        test_idle_line;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
